// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (CPU / IO channel) arbiter for a single-port memory.
// Each granted access takes IDLE -> ACCESS -> RESP. The CPU normally wins a tie,
// but an IO requester that has lost MAX_WAIT ties in a row is granted next.
module mem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic          io_ack,
    output logic [DW-1:0] io_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] io_wait;
    logic          grant_any;
    logic          grant_io;

    // Latched copy of the granted request; drives the memory port directly so
    // address and write data hold their last value once the access is over.
    logic          owner_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    // State register; reset returns to IDLE and aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and grant decision; the IO wins a tie only once starved.
    always_comb begin
        state_nxt = state;
        grant_any = 1'b0;
        grant_io  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_req || io_req) begin
                    grant_any = 1'b1;
                    grant_io  = io_req && (!cpu_req || (io_wait == WW'(MAX_WAIT)));
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the winning request at the grant so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_any) begin
            owner_q <= grant_io;
            we_q    <= grant_io ? io_we    : cpu_we;
            addr_q  <= grant_io ? io_addr  : cpu_addr;
            wdata_q <= grant_io ? io_wdata : cpu_wdata;
        end
    end

    // Count IO losses (saturating); an IO grant clears the count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            io_wait <= '0;
        end else if (grant_any) begin
            if (grant_io) begin
                io_wait <= '0;
            end else if (io_req && (io_wait != WW'(MAX_WAIT))) begin
                io_wait <= io_wait + WW'(1);
            end
        end
    end

    // Register memory read data at the end of ACCESS into the owner's port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cpu_rdata <= '0;
            io_rdata  <= '0;
        end else if ((state == ACCESS) && !we_q) begin
            if (owner_q) begin
                io_rdata <= mem_rdata;
            end else begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

    assign mem_en    = (state == ACCESS);
    assign mem_we    = (state == ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ack   = (state == RESP) && !owner_q;
    assign io_ack    = (state == RESP) && owner_q;
    assign busy      = (state != IDLE);
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x16 memory.
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, io_req, io_we;
    logic [AW-1:0] cpu_addr, io_addr;
    logic [DW-1:0] cpu_wdata, io_wdata;
    logic          cpu_ack, io_ack, mem_en, mem_we, busy, owner;
    logic [DW-1:0] cpu_rdata, io_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] mem [0:255];
    int checks = 0;
    int failures = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_ack(io_ack), .io_rdata(io_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Asynchronous-read, synchronous-write memory model
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 16'hBEEF;
        rst = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        io_req = 0;  io_we = 0;  io_addr = '0;  io_wdata = '0;

        // Reset state
        step(); step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_acks", 32'({cpu_ack, io_ack}), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_io_wait", 32'(dut.io_wait), 32'd0);
        rst = 1'b1;

        // Idle with no requests
        step(); step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_strobes", 32'({mem_en, mem_we, cpu_ack, io_ack}), 32'd0);

        // CPU read of 0x10
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        step();
        chk("cr_mem_en", 32'(mem_en), 32'd1);
        chk("cr_mem_we", 32'(mem_we), 32'd0);
        chk("cr_mem_addr", 32'(mem_addr), 32'h10);
        chk("cr_io_ack_a", 32'(io_ack), 32'd0);
        step();
        chk("cr_cpu_ack", 32'(cpu_ack), 32'd1);
        chk("cr_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
        chk("cr_io_ack_r", 32'(io_ack), 32'd0);
        chk("cr_mem_en_off", 32'(mem_en), 32'd0);
        cpu_req = 0;
        step();
        chk("cr_done", 32'({busy, cpu_ack}), 32'd0);

        // IO write of 0x1234 to 0x20
        io_req = 1; io_we = 1; io_addr = 8'h20; io_wdata = 16'h1234;
        step();
        chk("iw_strobes", 32'({mem_en, mem_we}), 32'h3);
        chk("iw_addr", 32'(mem_addr), 32'h20);
        chk("iw_wdata", 32'(mem_wdata), 32'h1234);
        chk("iw_owner", 32'(owner), 32'd1);
        step();
        chk("iw_acks", 32'({io_ack, cpu_ack}), 32'h2);
        chk("iw_mem_en_off", 32'({mem_en, mem_we}), 32'd0);
        chk("iw_addr_hold", 32'(mem_addr), 32'h20);
        io_req = 0; io_we = 0;
        step();
        chk("iw_mem", 32'(mem[8'h20]), 32'h1234);

        // Simultaneous requests, io_wait=0: CPU first, then IO
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        io_req = 1;  io_we = 0;  io_addr = 8'h20;
        step();
        chk("sim_owner_cpu", 32'(owner), 32'd0);
        chk("sim_io_wait1", 32'(dut.io_wait), 32'd1);
        io_addr = 8'h10; // ignored, latched copy in use
        step();
        chk("sim_cpu_ack", 32'({cpu_ack, io_ack}), 32'h2);
        cpu_req = 0; io_addr = 8'h20;
        step();
        chk("sim_idle", 32'(busy), 32'd0);
        step();
        chk("sim_owner_io", 32'(owner), 32'd1);
        chk("sim_io_wait0", 32'(dut.io_wait), 32'd0);
        chk("sim_io_addr", 32'(mem_addr), 32'h20);
        step();
        chk("sim_io_ack", 32'({cpu_ack, io_ack}), 32'h1);
        chk("sim_io_rdata", 32'(io_rdata), 32'h1234);
        io_req = 0;
        step();

        // Starvation: both held; four CPU grants, IO on the fifth
        cpu_req = 1; io_req = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("stv_owner%0d", k), 32'(owner), (k < 4) ? 32'd0 : 32'd1);
            chk($sformatf("stv_wait%0d", k), 32'(dut.io_wait), (k < 4) ? 32'(k + 1) : 32'd0);
            step();
            chk($sformatf("stv_ack%0d", k), 32'({cpu_ack, io_ack}), (k < 4) ? 32'h2 : 32'h1);
            if (k == 4) begin
                cpu_req = 0; io_req = 0;
            end
            step();
        end
        chk("stv_idle", 32'(busy), 32'd0);

        // Reset asserted during ACCESS aborts the transfer
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h30; cpu_wdata = 16'h5555;
        step();
        chk("ra_access", 32'(mem_en), 32'd1);
        rst = 1'b0;
        step();
        chk("ra_mem_en", 32'(mem_en), 32'd0);
        chk("ra_busy", 32'(busy), 32'd0);
        chk("ra_acks", 32'({cpu_ack, io_ack}), 32'd0);
        chk("ra_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b1;
        cpu_we = 0; cpu_addr = 8'h10;
        step();
        chk("ra2_mem_en", 32'(mem_en), 32'd1);
        chk("ra2_addr", 32'(mem_addr), 32'h10);
        step();
        chk("ra2_cpu_ack", 32'(cpu_ack), 32'd1);
        chk("ra2_rdata", 32'(cpu_rdata), 32'hBEEF);
        cpu_req = 0;
        step();
        chk("ra2_idle", 32'({busy, cpu_ack}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
